fpdiv_round_pack: RTL and testbench
===================================

FPDIV_ROUND_PACK -- requirements
Module: fpdiv_round_pack

Interface
REQ-001 Parameter: FW, default 28, number of fractional bits of in_quot; in_quot width is FW+2 (2.FW fixed point).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream divider presents a finished quotient.
REQ-005 in_ready  output  1  block accepts the input this cycle.
REQ-006 in_sign  input  1  result sign (dividend sign XOR divisor sign).
REQ-007 in_exp  input  10  biased exponent before normalization (ea-eb+127), two's complement.
REQ-008 in_quot  input  FW+2  quotient mantissa, 2.FW, value in [0.5,2).
REQ-009 in_rem_sign  input  1  final remainder N-Q*D negative.
REQ-010 in_rem_zero  input  1  final remainder exactly zero.
REQ-011 in_special  input  2  special_t: NONE, ZERO, INF, NAN.
REQ-012 in_rmode  input  2  round_mode_t: 00 RNE, 01 RZ, 10 RDN (to -inf), 11 RUP (to +inf).
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_result  output  32  IEEE-754 binary32 quotient.
REQ-016 out_flags  output  3  {OF, UF, NX}.

Function
REQ-017 Two-stage pipeline: S1 normalize/extract, S2 round/pack; latency 2 cycles from accepted input to out_valid with out_ready high; throughput 1 per cycle.
REQ-018 Handshake: transfer when valid&ready; s2_adv = ~out_valid|out_ready; in_ready = ~s1_valid|s2_adv; no combinational path from in_valid to in_ready.
REQ-019 While out_valid&~out_ready, out_result and out_flags SHALL remain stable and no operation is dropped, duplicated or reordered.
REQ-020 S1: if in_quot[FW]=1 use as is; else shift left 1 and decrement exponent.
REQ-021 S1: if in_rem_sign=1, subtract one LSB (2^-FW) from in_quot before extraction.
REQ-022 S1: mantissa = 24 bits from integer bit down; guard = next bit; sticky = OR of remaining bits OR ~in_rem_zero.
REQ-023 S2 increment: RNE guard&(sticky|lsb); RZ never; RDN sign&(guard|sticky); RUP ~sign&(guard|sticky).
REQ-024 Mantissa carry-out after increment SHALL renormalize to 1.0 and increment exponent.
REQ-025 NX = guard|sticky for finite non-special results.
REQ-026 Exponent >= 255 after rounding: OF=1, NX=1; result inf for RNE, RUP(+), RDN(-); otherwise max finite 0x7F7FFFFF with sign.
REQ-027 Exponent <= 0: flush to signed zero, UF=1, NX=1 (no subnormal output).
REQ-028 Specials bypass rounding, flags 0: ZERO -> sign|0x00000000; INF -> sign|0x7F800000; NAN -> 0x7FC00000.

Reset
REQ-029 Reset SHALL clear s1_valid, s2_valid, out_valid immediately (asynchronous), discarding in-flight operations.
REQ-030 out_result and out_flags reset to 0; in_ready is 1 during the first cycle after reset release.

Structure
REQ-031 Package fpdiv_pkg holds round_mode_t, special_t, FW default, bias 127, canonical NaN constant.
REQ-032 One sub-module round_decide: combinational increment decision from rmode, sign, lsb, guard, sticky.

Verification
REQ-033 in_quot=30'h18000000, exp=127, rem_zero=1, RNE -> 0x3FC00000, flags 000, out_valid 2 cycles later.
REQ-034 in_quot=30'h0C000000, exp=127, rem_zero=1 -> 0x3F400000 (normalization path).
REQ-035 RNE tie: in_quot=30'h10000010 -> 0x3F800000, NX=1; in_quot=30'h10000030 -> 0x3F800002, NX=1.
REQ-036 exp=10'h12C, in_quot=30'h10000000: RNE -> 0x7F800000 flags 101; RZ -> 0x7F7FFFFF flags 101.
REQ-037 Backpressure: 3 back-to-back inputs, out_ready low 3 cycles -> first result held stable, in_ready low after 2 accepted, all 3 results delivered in order.
REQ-038 Reset asserted with both stages valid -> out_valid 0 same cycle, no result emitted afterwards.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the divider round/pack back end.
//   round_mode_t : IEEE rounding direction selector
//   special_t    : special-case class of the quotient, resolved upstream
//   FW_DEFAULT   : fractional width of the 2.FW quotient mantissa
//   EXP_BIAS     : binary32 exponent bias
//   CANON_NAN    : quiet NaN pattern emitted for every NaN result
package fpdiv_pkg;

  localparam int FW_DEFAULT = 28;
  localparam int EXP_BIAS   = 127;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG   = 31'h7F80_0000;
  localparam logic [30:0] MAX_MAG   = 31'h7F7F_FFFF;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RZ  = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } round_mode_t;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_ZERO = 2'b01,
    SP_INF  = 2'b10,
    SP_NAN  = 2'b11
  } special_t;

endpackage

// File: rtl/fpdiv_round_pack_round_decide.sv
// round_decide: combinational round-up decision for a 24-bit mantissa.
//   rmode  : rounding mode
//   sign   : result sign
//   lsb    : mantissa LSB (tie breaker for round-to-nearest-even)
//   guard  : first bit below the LSB
//   sticky : OR of everything below guard, including a nonzero remainder
//   inc    : 1 when the mantissa must be incremented
module round_decide
  import fpdiv_pkg::*;
(
  input  round_mode_t rmode,
  input  logic        sign,
  input  logic        lsb,
  input  logic        guard,
  input  logic        sticky,
  output logic        inc
);

  always_comb begin
    inc = 1'b0;
    unique case (rmode)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RZ:   inc = 1'b0;
      RM_RDN:  inc = sign & (guard | sticky);
      RM_RUP:  inc = ~sign & (guard | sticky);
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpdiv_round_pack.sv
// fpdiv_round_pack: normalizes, rounds and packs a 2.FW divider quotient into
// IEEE-754 binary32 through a two-stage valid/ready pipeline.
//   clk, reset                : clock, asynchronous active-high reset
//   in_valid / in_ready       : upstream handshake
//   in_sign, in_exp, in_quot  : sign, biased pre-normalization exponent, quotient
//   in_rem_sign, in_rem_zero  : final remainder negative / exactly zero
//   in_special, in_rmode      : special class, rounding mode
//   out_valid / out_ready     : downstream handshake
//   out_result, out_flags     : binary32 result, {OF, UF, NX}
module fpdiv_round_pack
  import fpdiv_pkg::*;
#(
  parameter int FW = FW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [9:0]    in_exp,
  input  logic [FW+1:0] in_quot,
  input  logic          in_rem_sign,
  input  logic          in_rem_zero,
  input  special_t      in_special,
  input  round_mode_t   in_rmode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic [2:0]    out_flags
);

  // ---------------- stage 1: normalize / extract ----------------
  logic               s1_valid_reg;
  logic               s1_sign_reg;
  logic signed [10:0] s1_exp_reg;
  logic [23:0]        s1_mant_reg;
  logic               s1_guard_reg;
  logic               s1_sticky_reg;
  special_t           s1_special_reg;
  round_mode_t        s1_rmode_reg;

  logic               s2_valid_reg;
  logic               s2_adv;

  logic [FW+1:0]      q_adj;
  logic [FW:0]        q_norm;
  logic signed [10:0] exp_ext;
  logic signed [10:0] s1_exp_next;
  logic               unused_top;

  // A negative remainder means the quotient overshot by one LSB.
  assign q_adj      = in_quot - {{(FW+1){1'b0}}, in_rem_sign};
  // The integer bit above FW can only be set for out-of-range inputs.
  assign unused_top = q_adj[FW+1];
  assign exp_ext    = {in_exp[9], in_exp};
  assign q_norm     = q_adj[FW] ? q_adj[FW:0] : {q_adj[FW-1:0], 1'b0};
  assign s1_exp_next = q_adj[FW] ? exp_ext : exp_ext - 11'sd1;

  assign s2_adv    = ~s2_valid_reg | out_ready;
  assign in_ready  = ~s1_valid_reg | s2_adv;
  assign out_valid = s2_valid_reg;

  // ---------------- stage 2: round / pack ----------------
  logic               inc;
  logic [24:0]        mant_rnd;
  logic               carry;
  logic               unused_hidden;
  logic signed [10:0] exp_rnd;
  logic               nx;
  logic               to_inf;
  logic [31:0]        result_next;
  logic [2:0]         flags_next;

  round_decide u_round_decide (
    .rmode  (s1_rmode_reg),
    .sign   (s1_sign_reg),
    .lsb    (s1_mant_reg[0]),
    .guard  (s1_guard_reg),
    .sticky (s1_sticky_reg),
    .inc    (inc)
  );

  assign mant_rnd      = {1'b0, s1_mant_reg} + {24'd0, inc};
  // Carry-out means the mantissa rolled over to exactly 2.0: fraction becomes 0.
  assign carry         = mant_rnd[24];
  assign unused_hidden = mant_rnd[23];
  assign exp_rnd       = carry ? s1_exp_reg + 11'sd1 : s1_exp_reg;
  assign nx            = s1_guard_reg | s1_sticky_reg;
  assign to_inf        = (s1_rmode_reg == RM_RNE) ||
                         (s1_rmode_reg == RM_RUP && !s1_sign_reg) ||
                         (s1_rmode_reg == RM_RDN && s1_sign_reg);

  always_comb begin
    result_next = 32'd0;
    flags_next  = 3'b000;
    unique case (s1_special_reg)
      SP_ZERO: result_next = {s1_sign_reg, 31'd0};
      SP_INF:  result_next = {s1_sign_reg, INF_MAG};
      SP_NAN:  result_next = CANON_NAN;
      default: begin
        if (exp_rnd >= 11'sd255) begin
          result_next = {s1_sign_reg, to_inf ? INF_MAG : MAX_MAG};
          flags_next  = 3'b101;
        end else if (exp_rnd <= 11'sd0) begin
          // No subnormal output: tiny results flush to signed zero.
          result_next = {s1_sign_reg, 31'd0};
          flags_next  = 3'b011;
        end else begin
          result_next = {s1_sign_reg, exp_rnd[7:0],
                         carry ? 23'd0 : mant_rnd[22:0]};
          flags_next  = {2'b00, nx};
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg   <= 1'b0;
      s1_sign_reg    <= 1'b0;
      s1_exp_reg     <= 11'sd0;
      s1_mant_reg    <= 24'd0;
      s1_guard_reg   <= 1'b0;
      s1_sticky_reg  <= 1'b0;
      s1_special_reg <= SP_NONE;
      s1_rmode_reg   <= RM_RNE;
      s2_valid_reg   <= 1'b0;
      out_result     <= 32'd0;
      out_flags      <= 3'b000;
    end else begin
      if (in_ready) begin
        s1_valid_reg <= in_valid;
        if (in_valid) begin
          s1_sign_reg    <= in_sign;
          s1_exp_reg     <= s1_exp_next;
          s1_mant_reg    <= q_norm[FW -: 24];
          s1_guard_reg   <= q_norm[FW-24];
          s1_sticky_reg  <= (|q_norm[FW-25:0]) | ~in_rem_zero;
          s1_special_reg <= in_special;
          s1_rmode_reg   <= in_rmode;
        end
      end
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_result <= result_next;
          out_flags  <= flags_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpdiv_round_pack.sv
// Testbench for fpdiv_round_pack: directed cases with known results, a
// backpressure sequence, reset-in-flight, then randomized traffic checked
// against an arithmetic reference model through a scoreboard queue.
module tb_fpdiv_round_pack;
  import fpdiv_pkg::*;

  localparam int FW = 28;

  typedef struct {
    logic          sign;
    logic [9:0]    exp;
    logic [FW+1:0] quot;
    logic          rem_sign;
    logic          rem_zero;
    special_t      special;
    round_mode_t   rmode;
  } stim_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sign = 1'b0;
  logic [9:0]    in_exp = '0;
  logic [FW+1:0] in_quot = '0;
  logic          in_rem_sign = 1'b0;
  logic          in_rem_zero = 1'b1;
  special_t      in_special = SP_NONE;
  round_mode_t   in_rmode = RM_RNE;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_result;
  logic [2:0]    out_flags;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  stim_t cur;
  bit   dir_mode = 1'b0;
  exp_t dir_exp;
  bit   accepted = 1'b0;

  always #5 clk = ~clk;

  fpdiv_round_pack #(.FW(FW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp      (in_exp),
    .in_quot     (in_quot),
    .in_rem_sign (in_rem_sign),
    .in_rem_zero (in_rem_zero),
    .in_special  (in_special),
    .in_rmode    (in_rmode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: treat the quotient as an integer scaled by 2^FW and round it
  // to 24 significant bits by comparing the discarded part against one half.
  function automatic exp_t ref_model(stim_t s);
    exp_t  r;
    longint q, m, rest, half;
    int    e, sh;
    bit    inexact, above, tie, up;
    r.flags = 3'b000;
    if (s.special == SP_NAN) begin r.res = 32'h7FC00000; return r; end
    if (s.special == SP_ZERO) begin r.res = {s.sign, 31'd0}; return r; end
    if (s.special == SP_INF) begin r.res = {s.sign, 31'h7F800000}; return r; end
    q = longint'(s.quot) - longint'(s.rem_sign);
    e = int'(s.exp);
    if (e >= 512) e -= 1024;
    if (q < (64'sd1 << FW)) begin q = q * 2; e = e - 1; end
    sh = FW - 23;
    m = q >> sh;
    rest = q % (64'sd1 << sh);
    half = 64'sd1 << (sh - 1);
    inexact = (rest != 0) || !s.rem_zero;
    above = (rest > half) || (rest == half && !s.rem_zero);
    tie = (rest == half) && s.rem_zero;
    case (s.rmode)
      RM_RNE:  up = above || (tie && m[0]);
      RM_RZ:   up = 1'b0;
      RM_RDN:  up = s.sign && inexact;
      default: up = !s.sign && inexact;
    endcase
    if (up) m = m + 1;
    if (m == (64'sd1 << 24)) begin m = 64'sd1 << 23; e = e + 1; end
    if (e >= 255) begin
      r.flags = 3'b101;
      if (s.rmode == RM_RNE || (s.rmode == RM_RUP && !s.sign) || (s.rmode == RM_RDN && s.sign))
        r.res = {s.sign, 31'h7F800000};
      else
        r.res = {s.sign, 31'h7F7FFFFF};
    end else if (e <= 0) begin
      r.flags = 3'b011;
      r.res = {s.sign, 31'd0};
    end else begin
      r.flags = {2'b00, inexact};
      r.res = {s.sign, 8'(e), 23'(m - (64'sd1 << 23))};
    end
    return r;
  endfunction

  task automatic apply(input stim_t s);
    cur         = s;
    in_sign     = s.sign;
    in_exp      = s.exp;
    in_quot     = s.quot;
    in_rem_sign = s.rem_sign;
    in_rem_zero = s.rem_zero;
    in_special  = s.special;
    in_rmode    = s.rmode;
  endtask

  function automatic stim_t mk(input logic sg, input logic [9:0] e, input logic [FW+1:0] q,
                               input logic rs, input logic rz, input round_mode_t rm);
    stim_t s;
    s.sign = sg; s.exp = e; s.quot = q; s.rem_sign = rs; s.rem_zero = rz;
    s.special = SP_NONE; s.rmode = rm;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.sign     = 1'($urandom);
    s.exp      = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                             : 10'($urandom_range(97, 157));
    if ($urandom_range(0, 7) == 0) s.exp = 10'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0) s.exp = 10'($urandom_range(252, 257));
    s.quot     = 30'($urandom_range(32'h08000001, 32'h1FFFFFFF));
    if ($urandom_range(0, 3) == 0) s.quot = (s.quot & ~30'h1F) | 30'h10;
    if ($urandom_range(0, 7) == 0) s.quot = 30'h1FFFFFF8 | 30'($urandom_range(0, 7));
    s.rem_sign = ($urandom_range(0, 3) == 0);
    s.rem_zero = ($urandom_range(0, 1) == 0);
    s.special  = ($urandom_range(0, 7) == 0) ? special_t'($urandom_range(0, 3)) : SP_NONE;
    s.rmode    = round_mode_t'($urandom_range(0, 3));
    return s;
  endfunction

  // One clock: score outputs and record an acceptance at the falling edge,
  // then return 1 time unit after the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    accepted = 1'b0;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q[0];
        check("result", out_result, e.res);
        check("flags", {29'd0, out_flags}, {29'd0, e.flags});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (in_valid && in_ready) begin
      accepted = 1'b1;
      exp_q.push_back(dir_mode ? dir_exp : ref_model(cur));
    end
    @(posedge clk);
    #1;
  endtask

  // Single directed transaction with fixed expected value and latency check.
  task automatic directed(input string tag, input stim_t s, input logic [31:0] res, input logic [2:0] fl);
    dir_mode = 1'b1;
    dir_exp.res = res; dir_exp.flags = fl;
    apply(s);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    step();
    check({tag, "_lat2"}, {31'd0, out_valid}, 32'd1);
    step();
    dir_mode = 1'b0;
  endtask

  initial begin
    stim_t s;
    int    cyc;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outv", {31'd0, out_valid}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_flags", {29'd0, out_flags}, 32'd0);
    reset = 1'b0;
    check("rst_inrdy", {31'd0, in_ready}, 32'd1);

    directed("basic", mk(0, 10'd127, 30'h18000000, 0, 1, RM_RNE), 32'h3FC00000, 3'b000);
    directed("norm", mk(0, 10'd127, 30'h0C000000, 0, 1, RM_RNE), 32'h3F400000, 3'b000);
    directed("tie_even", mk(0, 10'd127, 30'h10000010, 0, 1, RM_RNE), 32'h3F800000, 3'b001);
    directed("tie_odd", mk(0, 10'd127, 30'h10000030, 0, 1, RM_RNE), 32'h3F800002, 3'b001);
    directed("of_rne", mk(0, 10'h12C, 30'h10000000, 0, 1, RM_RNE), 32'h7F800000, 3'b101);
    directed("of_rz", mk(0, 10'h12C, 30'h10000000, 0, 1, RM_RZ), 32'h7F7FFFFF, 3'b101);
    directed("uf", mk(1, 10'h3F0, 30'h10000000, 0, 1, RM_RNE), 32'h80000000, 3'b011);
    directed("carry", mk(0, 10'd127, 30'h1FFFFFF0, 0, 1, RM_RUP), 32'h40000000, 3'b001);
    directed("remneg", mk(0, 10'd127, 30'h10000000, 1, 0, RM_RZ), 32'h3F7FFFFF, 3'b001);
    s = mk(1, 10'd5, 30'h10000000, 0, 1, RM_RNE); s.special = SP_INF;
    directed("sp_inf", s, 32'hFF800000, 3'b000);
    s.special = SP_NAN;
    directed("sp_nan", s, 32'h7FC00000, 3'b000);

    // Backpressure: three back-to-back inputs against a stalled output.
    dir_mode = 1'b1;
    out_ready = 1'b0;
    dir_exp.res = 32'h3FC00000; dir_exp.flags = 3'b000;
    apply(mk(0, 10'd127, 30'h18000000, 0, 1, RM_RNE)); in_valid = 1'b1;
    check("bp_rdy0", {31'd0, in_ready}, 32'd1);
    step();
    dir_exp.res = 32'h3F400000; dir_exp.flags = 3'b000;
    apply(mk(0, 10'd127, 30'h0C000000, 0, 1, RM_RNE));
    check("bp_rdy1", {31'd0, in_ready}, 32'd1);
    step();
    dir_exp.res = 32'h3F800000; dir_exp.flags = 3'b001;
    apply(mk(0, 10'd127, 30'h10000010, 0, 1, RM_RNE));
    check("bp_rdy2", {31'd0, in_ready}, 32'd0);
    step();
    check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    step();
    step();
    out_ready = 1'b1;
    step();
    check("bp_c_taken", {31'd0, accepted}, 32'd1);
    in_valid = 1'b0;
    repeat (3) step();
    check("bp_drained", exp_q.size(), 32'd0);
    dir_mode = 1'b0;

    // Reset with both stages occupied.
    out_ready = 1'b0;
    apply(mk(0, 10'd127, 30'h18000000, 0, 1, RM_RNE)); in_valid = 1'b1;
    step();
    apply(mk(1, 10'd130, 30'h14000000, 0, 1, RM_RNE));
    step();
    in_valid = 1'b0;
    check("pre_rst_outv", {31'd0, out_valid}, 32'd1);
    #2 reset = 1'b1;
    #1 check("rst_async_outv", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst2_inrdy", {31'd0, in_ready}, 32'd1);
    check("rst2_result", out_result, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst2_noout", {31'd0, out_valid}, 32'd0);
    end

    // Randomized traffic with random backpressure.
    in_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 3) != 0);
        apply(rand_stim());
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    check("final_drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
